// File: rtl/uart_rx.sv
// Single-clock UART receiver: one bit per clk, start/8 data MSB-first/optional parity/stop,
// with a one-entry valid/ready holding register and overrun pulse.
module uart_rx #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   input  logic       parity_en,
   input  logic       even_parity,
   input  logic       rx_ready,
   output logic [7:0] data_out,
   output logic       rx_valid,
   output logic       parity_err,
   output logic       frame_err,
   output logic       overrun,
   output logic       rx_busy
);

   typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, WAIT_IDLE} state_t;

   state_t     state, state_nxt;
   logic       rx_s;
   logic [7:0] shift;
   logic [2:0] bit_cnt;
   logic       par_en_q, par_even_q, par_err_q;
   logic       frame_done, load;

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign rx_s = rx;
      end else if (SYNC_STAGES == 1) begin : g_sync1
         logic sync_q;
         always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) sync_q <= 1'b1;
            else        sync_q <= rx;
         assign rx_s = sync_q;
      end else begin : g_syncn
         logic [SYNC_STAGES-1:0] sync_q;
         always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) sync_q <= '1;
            else        sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
         assign rx_s = sync_q[SYNC_STAGES-1];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (!rx_s) state_nxt = DATA;
         DATA:      if (bit_cnt == 3'd7) state_nxt = par_en_q ? PARITY : STOP;
         PARITY:    state_nxt = STOP;
         STOP:      state_nxt = rx_s ? IDLE : WAIT_IDLE;
         WAIT_IDLE: if (rx_s) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_comb begin
      rx_busy    = (state == DATA) || (state == PARITY) || (state == STOP);
      frame_done = (state == STOP);
      load       = frame_done && (!rx_valid || rx_ready);
   end

   // Parity config is latched at the start bit so mid-frame input changes are ignored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift      <= '0;
         bit_cnt    <= '0;
         par_en_q   <= 1'b0;
         par_even_q <= 1'b0;
         par_err_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (!rx_s) begin
                  bit_cnt    <= '0;
                  par_en_q   <= parity_en;
                  par_even_q <= even_parity;
                  par_err_q  <= 1'b0;
               end
            end
            DATA: begin
               shift   <= {shift[6:0], rx_s};
               bit_cnt <= bit_cnt + 3'd1;
            end
            PARITY:  par_err_q <= rx_s != (par_even_q ? ^shift : ~^shift);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out   <= '0;
         rx_valid   <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (rx_valid && rx_ready) rx_valid <= 1'b0;
         if (load) begin
            data_out   <= shift;
            parity_err <= par_err_q;
            frame_err  <= ~rx_s;
            rx_valid   <= 1'b1;
         end else if (frame_done) begin
            overrun <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames queued on a scoreboard at send time, popped on each
// valid/ready transfer; latency, overrun and reset behaviour checked inline.
module tb_uart_rx;
   localparam int unsigned S = 2;

   typedef struct packed {
      logic [7:0] d;
      logic       pe;
      logic       fe;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx = 1'b1;
   logic       parity_en = 1'b0;
   logic       even_parity = 1'b0;
   logic       rx_ready = 1'b0;
   logic [7:0] data_out;
   logic       rx_valid, parity_err, frame_err, overrun, rx_busy;

   exp_t exp_q[$];
   exp_t exp_e;
   int   compared = 0;
   int   mismatched = 0;
   int   cyc = 0;
   int   ovr_cnt = 0;
   int   last_rise = -1;
   int   start_cyc = 0;
   int   ovr_base = 0;
   logic valid_prev = 1'b0;

   uart_rx #(.SYNC_STAGES(S)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx         (rx),
      .parity_en  (parity_en),
      .even_parity(even_parity),
      .rx_ready   (rx_ready),
      .data_out   (data_out),
      .rx_valid   (rx_valid),
      .parity_err (parity_err),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .rx_busy    (rx_busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      compared++;
      assert (obs === expv) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Scoreboard side: every transfer must match the oldest queued frame.
   always @(negedge clk) begin
      if (!rst_n) begin
         valid_prev = 1'b0;
      end else begin
         if (rx_valid && !valid_prev) last_rise = cyc;
         valid_prev = rx_valid;
         if (overrun) ovr_cnt++;
         if (rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_frame", 32'(rx_valid), 32'd0);
            end else begin
               exp_e = exp_q.pop_front();
               chk("sb_data", 32'(data_out), 32'(exp_e.d));
               chk("sb_parity_err", 32'(parity_err), 32'(exp_e.pe));
               chk("sb_frame_err", 32'(frame_err), 32'(exp_e.fe));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) tick();
   endtask

   task automatic wait_done();
      repeat (S) tick();
   endtask

   task automatic send_frame(input logic [7:0] d, input logic pen, input logic ev,
                             input logic bad_par, input logic stop_b, input logic push,
                             input logic wobble);
      logic pb;
      parity_en   = pen;
      even_parity = ev;
      if (push) exp_q.push_back('{d: d, pe: pen & bad_par, fe: ~stop_b});
      start_cyc = cyc;
      rx = 1'b0;
      tick();
      for (int i = 7; i >= 0; i--) begin
         rx = d[i];
         if (wobble && i == 4) begin
            parity_en   = ~pen;
            even_parity = ~ev;
         end
         tick();
      end
      if (pen) begin
         pb = ev ? ^d : ~^d;
         rx = pb ^ bad_par;
         tick();
      end
      rx = stop_b;
      tick();
      parity_en   = pen;
      even_parity = ev;
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) tick();
      chk("rst_data_out", 32'(data_out), 32'h00);
      chk("rst_rx_valid", 32'(rx_valid), 32'd0);
      chk("rst_parity_err", 32'(parity_err), 32'd0);
      chk("rst_frame_err", 32'(frame_err), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      chk("rst_rx_busy", 32'(rx_busy), 32'd0);
      rst_n = 1'b1;
      idle(3);

      // even parity 0xA5, ready high
      rx_ready = 1'b1;
      send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("a5_busy_mid", 32'(rx_busy), 32'd1);
      wait_done();
      chk("a5_valid", 32'(rx_valid), 32'd1);
      chk("a5_data", 32'(data_out), 32'hA5);
      chk("a5_parity_err", 32'(parity_err), 32'd0);
      chk("a5_frame_err", 32'(frame_err), 32'd0);
      chk("a5_busy_done", 32'(rx_busy), 32'd0);
      tick();
      chk("a5_valid_one_cycle", 32'(rx_valid), 32'd0);
      chk("a5_latency", 32'(last_rise - start_cyc), 32'(S + 11));

      // odd parity with a deliberately wrong parity bit
      idle(3);
      send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      wait_done();
      chk("3c_valid", 32'(rx_valid), 32'd1);
      chk("3c_data", 32'(data_out), 32'h3C);
      chk("3c_parity_err", 32'(parity_err), 32'd1);
      idle(3);
      send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      wait_done();
      chk("81_valid", 32'(rx_valid), 32'd1);
      chk("81_data", 32'(data_out), 32'h81);
      chk("81_parity_err", 32'(parity_err), 32'd0);
      tick();
      chk("81_latency", 32'(last_rise - start_cyc), 32'(S + 10));

      // stop bit 0 then line held low
      idle(3);
      send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      rx = 1'b0;
      wait_done();
      chk("55_valid", 32'(rx_valid), 32'd1);
      chk("55_data", 32'(data_out), 32'h55);
      chk("55_frame_err", 32'(frame_err), 32'd1);
      repeat (3) tick();
      chk("break_busy", 32'(rx_busy), 32'd0);
      chk("break_valid", 32'(rx_valid), 32'd0);
      rx = 1'b1;
      tick();
      send_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      wait_done();
      chk("0f_valid", 32'(rx_valid), 32'd1);
      chk("0f_data", 32'(data_out), 32'h0F);
      chk("0f_frame_err", 32'(frame_err), 32'd0);

      // overrun: back-to-back with consumer stalled
      idle(3);
      rx_ready = 1'b0;
      ovr_base = ovr_cnt;
      send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      wait_done();
      tick();
      chk("ovr_valid", 32'(rx_valid), 32'd1);
      chk("ovr_data_held", 32'(data_out), 32'h11);
      chk("ovr_pulses", 32'(ovr_cnt - ovr_base), 32'd1);
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
      chk("ovr_valid_drop", 32'(rx_valid), 32'd0);

      // consume on the exact completion edge of the next frame
      idle(2);
      send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      idle(4);
      ovr_base = ovr_cnt;
      send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      repeat (S - 1) tick();
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
      chk("edge_valid", 32'(rx_valid), 32'd1);
      chk("edge_data", 32'(data_out), 32'h22);
      tick();
      chk("edge_no_overrun", 32'(ovr_cnt - ovr_base), 32'd0);
      chk("edge_data_stable", 32'(data_out), 32'h22);
      rx_ready = 1'b1;
      tick();
      chk("edge_valid_drop", 32'(rx_valid), 32'd0);

      // reset mid-frame
      idle(3);
      rx = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         rx = 1'b1;
         tick();
      end
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", 32'(rx_valid), 32'd0);
      chk("midrst_data", 32'(data_out), 32'h00);
      chk("midrst_busy", 32'(rx_busy), 32'd0);
      rx = 1'b1;
      tick();
      tick();
      rst_n = 1'b1;
      idle(3);
      send_frame(8'h99, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      wait_done();
      chk("99_valid", 32'(rx_valid), 32'd1);
      chk("99_data", 32'(data_out), 32'h99);

      idle(4);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      chk("total_overruns", 32'(ovr_cnt), 32'd1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
